uart_rx_engine: RTL
===================

// Module: uart_rx_engine
// PURPOSE
//  Parametrised UART receive engine: the successor to the fixed 8-bit receive controller.
//  Syncs rx; detects and validates the start bit; samples 5..DATA_MAX data bits, optional parity and 1/2 stops.
//  Outputs a right-justified word with a valid/read handshake, plus parity/framing/overrun status.
//  Sits between the rx pin and the bus-side register file; divisor comes from the baud decoder.
// PARAMETERS
//  DATA_MAX     8   widest data field supported (>=5)
//  DIV_W        19  width of bit-time divisor k
//  SYNC_STAGES  2   rx synchroniser flops (>=2)
// PORTS
//  clk         in   1            single system clock
//  rst         in   1            synchronous, active-high reset
//  rx          in   1            async serial input, idle high
//  data_len    in   4            data bits per frame, 5..DATA_MAX; out-of-range = DATA_MAX
//  pen         in   1            parity enable
//  odd_par     in   1            1=odd, 0=even parity
//  two_stop    in   1            1=check two stop bits
//  k           in   DIV_W        clocks per bit time; 0 treated as 1
//  rx_rd       in   1            consumer read strobe, clears rx_valid/status
//  rx_data     out  DATA_MAX     received word, right-justified, unused MSBs 0
//  rx_valid    out  1            word held, level until rx_rd
//  parity_err  out  1            parity mismatch on held word
//  frame_err   out  1            any stop bit sampled 0
//  overrun     out  1            word overwritten while rx_valid=1 (sticky to rx_rd)
//  break_det   out  1            break frame received (see CONFIGURATION)
//  busy        out  1            FSM not IDLE
//  btu         out  1            1-cycle bit-time-up pulse (sample strobe)
// BEHAVIOUR
//  Reset: every output 0; synchroniser flops preset to 1; FSM=IDLE; counters 0.
//  States: IDLE->START->DATA->[PARITY]->STOP1->[STOP2]->IDLE (BREAK with macro).
//  IDLE: synced rx=0 -> START; data_len/pen/odd_par/two_stop/k latched here, held for whole frame.
//  START: timer loaded k>>1 (min 1); on btu sample rx: 1 = false start -> IDLE, no flags; 0 -> DATA.
//  DATA/PARITY/STOP: timer reloads k each bit; sample on btu; data LSB-first into shift reg.
//  Parity: XOR of data_len bits ^ odd_par vs received bit; skipped when pen=0, parity_err=0.
//  Last stop sampled: next cycle rx_data/errors update, rx_valid=1, FSM->IDLE same cycle (resync mid-stop).
//  rx_rd with rx_valid=0: no effect. rx_rd same cycle as new-word load: new word held, rx_valid stays 1, overrun 0.
//  New word while rx_valid=1 and no rd: word overwritten, overrun=1.
//  Reset mid-frame: aborts to IDLE, partial word discarded.
//  Timer: DIV_W-bit down-counter, btu when it reaches 1; no wrap beyond reload value.
// CONFIGURATION
//  Macro RX_BREAK_DETECT_EN.
//  Defined: data=0, parity bit (if pen)=0 and stop1=0 -> break_det=1 with frame_err=1,
//   rx_data=0; FSM enters BREAK, waits for synced rx=1 before IDLE (no false starts).
//  Undefined: break_det tied 0; such frame reports frame_err only, returns to IDLE directly.
// STRUCTURE
//  Package uart_pkg: rx_state_t enum, DATA_MIN=5 constant, parity encode constants.
//  Sub-module rx_bit_timer: loadable DIV_W down-counter producing btu.
//  Synchroniser, FSM, shift/align, status regs inline.
// TESTING (k=16, SYNC_STAGES=2)
//  8N1 0xA5, single stop -> rx_data=0xA5, rx_valid=1, all errors 0; low after rx_rd.
//  7E1 0x41 with parity bit inverted -> rx_data=0x41, parity_err=1; correct parity -> parity_err=0.
//  rx low 4 clk then high -> START sample reads 1, FSM back to IDLE, rx_valid stays 0.
//  8N2, second stop 0 -> frame_err=1; same frame two_stop=0 -> frame_err=0.
//  Frames 0x11 then 0x22, no rx_rd -> rx_data=0x22, overrun=1; rx_rd clears both flags.
//  Break (rx low 12 bit times), macro on -> break_det=1, no new start until rx high; off -> frame_err=1 only.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receive FSM states, data-width floor and parity encoding for uart_rx_engine
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} rx_state_t;
  localparam int DATA_MIN = 5;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  function automatic logic par_bit(input logic [31:0] d, input logic odd);
    return (odd ? PAR_ODD : PAR_EVEN) ^ (^d);
  endfunction
endpackage

// File: rtl/uart_rx_engine_if.sv
// uart_rx_engine_if: receive-word bus (rx_data/rx_valid/status out of master, rx_rd into master)
interface uart_rx_engine_if #(parameter int DATA_MAX = 8);
  logic rx_rd;
  logic [DATA_MAX-1:0] rx_data;
  logic rx_valid;
  logic parity_err;
  logic frame_err;
  logic overrun;
  logic break_det;
  modport master(output rx_data, rx_valid, parity_err, frame_err, overrun, break_det, input rx_rd);
  modport slave(input rx_data, rx_valid, parity_err, frame_err, overrun, break_det, output rx_rd);
endinterface

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: loadable down-counter (clk, rst, load, val in; btu out) pulsing btu when it reaches 1
module rx_bit_timer #(parameter int DIV_W = 19) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
  output logic             btu
);
  logic [DIV_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign btu = cnt == DIV_W'(1);
endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receiver (clk/rst, rx pin, data_len/pen/odd_par/two_stop/k frame config, bus master port, busy/btu); RX_BREAK_DETECT_EN enables break detection
module uart_rx_engine import uart_pkg::*; #(
  parameter int DATA_MAX    = 8,
  parameter int DIV_W       = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [3:0]       data_len,
  input  logic             pen,
  input  logic             odd_par,
  input  logic             two_stop,
  input  logic [DIV_W-1:0] k,
  uart_rx_engine_if.master bus,
  output logic             busy,
  output logic             btu
);
  rx_state_t st, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic rxs, load, done, ferr, perr, brk;
  logic pen_q, odd_q, two_q, par_q, stop1_q;
  logic [3:0] len_q, cnt_b, cfg_len;
  logic [DIV_W-1:0] k_q, k_in, val;
  logic [DATA_MAX-1:0] sh, word;
  assign rxs = sync[SYNC_STAGES-1];
  assign k_in = k == '0 ? DIV_W'(1) : k;
  assign cfg_len = (data_len < 4'(DATA_MIN) || data_len > 4'(DATA_MAX)) ? 4'(DATA_MAX) : data_len;
  assign word = sh >> (4'(DATA_MAX) - len_q);
  assign busy = st != IDLE;
  assign ferr = st == STOP2 ? (!stop1_q || !rxs) : !rxs;
  assign perr = pen_q && (par_q != par_bit(32'(word), odd_q));
`ifdef RX_BREAK_DETECT_EN
  assign brk = st == STOP1 && word == '0 && !(pen_q && par_q) && !rxs;
`else
  assign brk = 1'b0;
`endif
  rx_bit_timer #(.DIV_W(DIV_W)) u_timer (.clk(clk), .rst(rst), .load(load), .val(val), .btu(btu));
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    load = 1'b0;
    val = k_q;
    done = 1'b0;
    case (st)
      IDLE: if (!rxs) begin
        nxt = START;
        load = 1'b1;
        val = (k_in >> 1) == '0 ? DIV_W'(1) : k_in >> 1;
      end
      START: if (btu) begin
        nxt = rxs ? IDLE : DATA;
        load = !rxs;
      end
      DATA: if (btu) begin
        load = 1'b1;
        nxt = cnt_b != len_q - 4'd1 ? DATA : pen_q ? PARITY : STOP1;
      end
      PARITY: if (btu) begin
        load = 1'b1;
        nxt = STOP1;
      end
      STOP1: if (btu) begin
        nxt = brk ? BREAK : two_q ? STOP2 : IDLE;
        load = two_q && !brk;
        done = brk || !two_q;
      end
      STOP2: if (btu) begin
        nxt = IDLE;
        done = 1'b1;
      end
      BREAK: nxt = rxs ? IDLE : BREAK;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '1;
      {pen_q, odd_q, two_q, par_q, stop1_q} <= '0;
      len_q <= '0;
      cnt_b <= '0;
      k_q <= '0;
      sh <= '0;
      bus.rx_data <= '0;
      {bus.rx_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.break_det} <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (st == IDLE && !rxs) begin
        len_q <= cfg_len;
        pen_q <= pen;
        odd_q <= odd_par;
        two_q <= two_stop;
        k_q <= k_in;
        cnt_b <= '0;
      end
      if (btu && st == DATA) begin
        sh <= {rxs, sh[DATA_MAX-1:1]};
        cnt_b <= cnt_b + 4'd1;
      end
      if (btu && st == PARITY) par_q <= rxs;
      if (btu && st == STOP1) stop1_q <= rxs;
      if (done) begin
        bus.rx_data <= word;
        bus.rx_valid <= 1'b1;
        bus.parity_err <= perr;
        bus.frame_err <= ferr;
        bus.break_det <= brk;
        // a read in the same cycle as the load consumes the old word, so no overrun
        bus.overrun <= bus.rx_valid && !bus.rx_rd;
      end else if (bus.rx_rd && bus.rx_valid)
        {bus.rx_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.break_det} <= '0;
    end
endmodule
